// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, fixed 33-cycle latency with start/busy/done handshake.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic            Flush,
  input  logic [2:0]      MdOp,
  input  logic [XLEN-1:0] Operand1,
  input  logic [XLEN-1:0] Operand2,
  output logic [XLEN-1:0] MdOut,
  output logic            Busy,
  output logic            Done
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc, acc_step;
  logic              neg_res, div_zero;

  logic              accept, last;
  logic              signed_a, signed_b, sign_a, sign_b, neg_start;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     trial;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_raw, result;

  assign accept = (state != CALC) && Start && !Flush;
  assign last   = (cnt == CW'(ITER - 1));
  assign Busy   = (state == CALC);
  assign Done   = (state == DONE);

  // Operand conditioning at acceptance: signedness per funct3, magnitudes and result sign.
  always_comb begin
    signed_a  = MdOp[2] ? !MdOp[0] : (MdOp != 3'b011);
    signed_b  = MdOp[2] ? !MdOp[0] : !MdOp[1];
    sign_a    = signed_a && Operand1[XLEN-1];
    sign_b    = signed_b && Operand2[XLEN-1];
    mag_a     = sign_a ? -Operand1 : Operand1;
    mag_b     = sign_b ? -Operand2 : Operand2;
    neg_start = (MdOp[2] && MdOp[1]) ? sign_a : (sign_a ^ sign_b);
  end

  // One radix-2 step: multiply shifts the product right, divide shifts the
  // partial remainder left and shifts a quotient bit into the low end.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    trial    = acc[2*XLEN-1:XLEN-1];
    diff     = {1'b0, trial} - {2'b00, opnd};
    acc_step = acc;
    if (!op[2])
      acc_step = {mul_sum, acc[XLEN-1:1]};
    else if (!diff[XLEN+1])
      acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_step = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  // Signed overflow (min / -1) already yields quotient min and remainder 0 from
  // the magnitude path; only the divide-by-zero quotient needs an override.
  always_comb begin
    prod    = neg_res ? -acc_step : acc_step;
    div_raw = op[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    if (!op[2])
      result = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (div_zero && !op[1])
      result = '1;
    else
      result = neg_res ? -div_raw : div_raw;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = accept ? CALC : IDLE;
      CALC:       state_next = last ? DONE : CALC;
      default:    state_next = IDLE;
    endcase
    if (Flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      MdOut <= '0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= '0;
      else if (state == CALC)
        cnt <= cnt + CW'(1);
      if (state == CALC && last && !Flush)
        MdOut <= result;
    end
  end

  // NOTE: datapath registers are qualified by the FSM and never read before a
  // load, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op       <= MdOp;
      neg_res  <= neg_start;
      div_zero <= (Operand2 == '0);
      if (MdOp[2]) begin
        opnd <= mag_b;
        acc  <= {{XLEN{1'b0}}, mag_a};
      end else begin
        opnd <= mag_a;
        acc  <= {{XLEN{1'b0}}, mag_b};
      end
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and model-checked stimulus for muldiv_unit: results, 33-cycle latency,
// flush, reset, ignored start and back-to-back handshakes.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start, Flush;
  logic [2:0]  MdOp;
  logic [31:0] Operand1, Operand2;
  logic [31:0] MdOut;
  logic        Busy, Done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                         DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Flush(Flush), .MdOp(MdOp),
    .Operand1(Operand1), .Operand2(Operand2), .MdOut(MdOut), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MUL:    begin sp = longint'(sa) * longint'(sb); up = sp; return up[31:0]; end
      MULH:   begin sp = longint'(sa) * longint'(sb); up = sp; return up[63:32]; end
      MULHSU: begin sp = longint'(sa) * longint'({32'b0, b}); up = sp; return up[63:32]; end
      MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      DIV:    if (b == 0) return 32'hFFFFFFFF;
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
              else return sa / sb;
      DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      REM:    if (b == 0) return a;
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
              else return sa % sb;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at #1 after the acceptance edge; counts edges until Done (bounded).
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (!Done && edges < 60) begin
      if (Busy) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MdOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    MdOp = 3'($urandom); Operand1 = $urandom; Operand2 = $urandom;
  endtask

  // Done arrives 32 edges after the acceptance edge: the 33rd cycle counting
  // the acceptance cycle, with Busy high for the 32 cycles in between.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit timing);
    int edges, busy_cnt;
    launch(op, a, b);
    wait_done(edges, busy_cnt);
    if (timing) begin
      check({tag, "_lat"}, edges, 32);
      check({tag, "_busy"}, busy_cnt, 32);
    end
    check(tag, MdOut, exp);
  endtask

  initial begin
    int edges, busy_cnt, e2, dones;
    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; MdOp = '0; Operand1 = '0; Operand2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mdout", MdOut, 32'h0);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_done", {31'b0, Done}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    do_op("mul_7_m3",     MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1);
    do_op("mulhu_m1",     MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
    do_op("mulh_m1",      MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1);
    do_op("mulhsu_m1_2",  MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1);
    do_op("mul_min_min",  MUL,    32'h80000000, 32'h80000000, 32'h00000000, 0);
    do_op("mulh_min_min", MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0);
    do_op("mulhsu_min",   MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    do_op("div_m7_2",     DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1);
    do_op("rem_m7_2",     REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1);
    do_op("divu_100_7",   DIVU,   32'd100,      32'd7,        32'd14,       0);
    do_op("remu_100_7",   REMU,   32'd100,      32'd7,        32'd2,        0);
    do_op("div_5_0",      DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    do_op("remu_5_0",     REMU,   32'd5,        32'd0,        32'd5,        1);
    do_op("div_m5_0",     DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 0);
    do_op("rem_m5_0",     REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 0);
    do_op("div_ovf",      DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem_ovf",      REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Start pulsed mid-CALC with different operands must be ignored.
    launch(MUL, 32'd7, 32'hFFFFFFFD);
    @(negedge clk);
    MdOp = MUL; Operand1 = 32'd3; Operand2 = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    wait_done(edges, busy_cnt);
    check("ign_start_lat", edges + 1, 32);
    check("ign_start_res", MdOut, 32'hFFFFFFEB);

    // Back-to-back: Start presented during the DONE cycle.
    launch(DIVU, 32'd100, 32'd7);
    wait_done(edges, busy_cnt);
    check("b2b_first", MdOut, 32'd14);
    MdOp = REMU; Operand1 = 32'd100; Operand2 = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    check("b2b_done_gap", {31'b0, Done}, 32'h0);
    check("b2b_busy", {31'b0, Busy}, 32'h1);
    wait_done(e2, busy_cnt);
    check("b2b_spacing", e2 + 1, 33);
    check("b2b_second", MdOut, 32'd2);

    // Flush in the 10th CALC cycle of a DIV: abort, no Done, MdOut held.
    launch(DIV, 32'hFFFFFFF9, 32'd2);
    repeat (9) @(posedge clk);
    @(negedge clk) Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check("flush_busy", {31'b0, Busy}, 32'h0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (Done) dones++;
    end
    check("flush_no_done", dones, 0);
    check("flush_mdout", MdOut, 32'd2);

    // Start and Flush together: not accepted.
    @(negedge clk);
    MdOp = MUL; Operand1 = 32'd5; Operand2 = 32'd5; Start = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    check("start_flush_busy", {31'b0, Busy}, 32'h0);

    // Synchronous reset in the middle of CALC.
    launch(DIVU, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_mdout", MdOut, 32'h0);
    check("midrst_busy", {31'b0, Busy}, 32'h0);
    check("midrst_done", {31'b0, Done}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    do_op("after_rst", DIVU, 32'd1000, 32'd3, 32'd333, 1);

    // Model-checked random operations with frequent small and zero operands.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h80000000;
      do_op("rand", op, a, b, ref_md(op, a, b), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
